// File: rtl/rv32i_clint.sv
// rv32i_clint: machine timer (mtime/mtimecmp), software (msip) and external interrupt controller.
// Latency: bus requests are acked with registered o_rdata one cycle later; ext irq is 3 edges from pin.
// No back-pressure: a request may be issued every cycle; reads return pre-write values.
module rv32i_clint #(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter bit          EXT_EDGE     = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [7:0]        i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wr_mask,
  output logic [31:0]       o_rdata,
  output logic              o_ack,
  input  logic [NUM_CH-1:0] i_ext_irq,
  output logic [NUM_CH-1:0] o_timer_irq,
  output logic [NUM_CH-1:0] o_software_irq,
  output logic [NUM_CH-1:0] o_external_irq
);

  // Prescaler needs at least one bit even when every clock is a tick.
  localparam int unsigned   PW        = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_MHZ - 1);

  // Word indices (byte offset / 4); mtimecmp[k] lives at words 4+2k / 5+2k.
  localparam logic [5:0] W_MTIME_LO = 6'd0;
  localparam logic [5:0] W_MTIME_HI = 6'd1;
  localparam logic [5:0] W_CTRL     = 6'd2;
  localparam logic [5:0] W_MSIP     = 6'd20;
  localparam logic [5:0] W_PEND     = 6'd21;

  logic [PW-1:0]     presc_q, presc_d;
  logic [63:0]       mtime_q, mtime_d;
  logic              ctrl_q, ctrl_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [63:0]       cmp_q [NUM_CH];
  logic [63:0]       cmp_d [NUM_CH];
  logic [NUM_CH-1:0] msip_q, msip_d;
  logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0] ext_lvl_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] timer_q, timer_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q;

  logic [5:0]        word;
  logic              tick;
  logic [31:0]       wmask;
  logic [31:0]       wbits;
  logic [31:0]       msip_tmp;
  logic [NUM_CH-1:0] ext_rise;
  logic [NUM_CH-1:0] ext_clr;
  logic              unused_addr;

  assign word        = i_addr[7:2];
  assign unused_addr = ^i_addr[1:0];
  assign wmask       = {{8{i_wr_mask[3]}}, {8{i_wr_mask[2]}}, {8{i_wr_mask[1]}}, {8{i_wr_mask[0]}}};
  assign wbits       = i_wdata & wmask;

  // Byte-lane merge of the write data into an existing 32-bit register value.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] m, input logic [31:0] b);
    merge = (old_v & ~m) | b;
  endfunction

  // Next-state for timer, control, compare, msip and pending registers.
  always_comb begin
    tick    = ctrl_q && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (ctrl_q) presc_d = tick ? '0 : presc_q + PW'(1);

    // A bus write to either mtime word pre-empts the tick in that cycle.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (i_wr_en && (word == W_MTIME_LO || word == W_MTIME_HI)) begin
      mtime_d = mtime_q;
      if (word == W_MTIME_LO) mtime_d[31:0]  = merge(mtime_q[31:0],  wmask, wbits);
      if (word == W_MTIME_HI) mtime_d[63:32] = merge(mtime_q[63:32], wmask, wbits);
    end

    ctrl_d = ctrl_q;
    if (i_wr_en && word == W_CTRL && i_wr_mask[0]) ctrl_d = i_wdata[0];

    // Reading the low word freezes the high word so the pair is coherent.
    shadow_d = shadow_q;
    if (i_rd_en && word == W_MTIME_LO) shadow_d = mtime_q[63:32];

    for (int k = 0; k < NUM_CH; k++) begin
      cmp_d[k] = cmp_q[k];
      if (i_wr_en && word == 6'(4 + 2 * k)) cmp_d[k][31:0]  = merge(cmp_q[k][31:0],  wmask, wbits);
      if (i_wr_en && word == 6'(5 + 2 * k)) cmp_d[k][63:32] = merge(cmp_q[k][63:32], wmask, wbits);
      timer_d[k] = (mtime_q >= cmp_q[k]);
    end

    msip_tmp = 32'(msip_q);
    if (i_wr_en && word == W_MSIP) msip_tmp = merge(msip_tmp, wmask, wbits);
    msip_d = msip_tmp[NUM_CH-1:0];

    // Edge capture: a new rising edge beats a simultaneous W1C.
    ext_rise = sync2_q & ~sync3_q;
    ext_clr  = (i_wr_en && word == W_PEND) ? wbits[NUM_CH-1:0] : '0;
    pend_d   = EXT_EDGE ? ((pend_q & ~ext_clr) | ext_rise) : '0;
  end

  // Read mux sampled from current register state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (i_rd_en) begin
      rdata_d = '0;
      case (word)
        W_MTIME_LO: rdata_d = mtime_q[31:0];
        W_MTIME_HI: rdata_d = shadow_q;
        W_CTRL:     rdata_d = {31'd0, ctrl_q};
        W_MSIP:     rdata_d[NUM_CH-1:0] = msip_q;
        W_PEND:     rdata_d[NUM_CH-1:0] = EXT_EDGE ? pend_q : ext_lvl_q;
        default: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (word == 6'(4 + 2 * k)) rdata_d = cmp_q[k][31:0];
            if (word == 6'(5 + 2 * k)) rdata_d = cmp_q[k][63:32];
          end
        end
      endcase
    end
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q   <= '0;
      mtime_q   <= '0;
      ctrl_q    <= 1'b1;
      shadow_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) cmp_q[k] <= '1;
      msip_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      ext_lvl_q <= '0;
      pend_q    <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      mtime_q   <= mtime_d;
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      for (int k = 0; k < NUM_CH; k++) cmp_q[k] <= cmp_d[k];
      msip_q    <= msip_d;
      sync1_q   <= i_ext_irq;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      ext_lvl_q <= sync2_q;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      ack_q     <= i_wr_en | i_rd_en;
    end
  end

  assign o_rdata        = rdata_q;
  assign o_ack          = ack_q;
  assign o_timer_irq    = timer_q;
  assign o_software_irq = msip_q;
  assign o_external_irq = EXT_EDGE ? pend_q : ext_lvl_q;

endmodule

// File: tb/tb_rv32i_clint.sv
// tb_rv32i_clint: scoreboard bench for rv32i_clint (NUM_CH=4, CLK_FREQ_MHZ=4, EXT_EDGE=1).
// Reads push expected data when issued; the monitor pops on the cycle after each request.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rv32i_clint;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           i_rst_n;
  logic           i_wr_en;
  logic           i_rd_en;
  logic [7:0]     i_addr;
  logic [31:0]    i_wdata;
  logic [3:0]     i_wr_mask;
  logic [31:0]    o_rdata;
  logic           o_ack;
  logic [NCH-1:0] i_ext_irq;
  logic [NCH-1:0] o_timer_irq;
  logic [NCH-1:0] o_software_irq;
  logic [NCH-1:0] o_external_irq;

  int n_chk = 0;
  int n_err = 0;
  bit req_seen = 1'b0;

  bit          sb_rd [$];
  logic [31:0] sb_exp[$];
  string       sb_tag[$];
  bit          mon_rd;
  logic [31:0] mon_exp;
  string       mon_tag;

  always #5 clk = ~clk;

  rv32i_clint #(.NUM_CH(NCH), .CLK_FREQ_MHZ(4), .EXT_EDGE(1'b1)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wr_mask(i_wr_mask),
    .o_rdata(o_rdata), .o_ack(o_ack), .i_ext_irq(i_ext_irq),
    .o_timer_irq(o_timer_irq), .o_software_irq(o_software_irq), .o_external_irq(o_external_irq)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
    i_wr_en = 1'b1; i_addr = a; i_wdata = d; i_wr_mask = m;
    sb_rd.push_back(1'b0); sb_exp.push_back(32'd0); sb_tag.push_back("wr");
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    i_rd_en = 1'b1; i_addr = a;
    sb_rd.push_back(1'b1); sb_exp.push_back(exp); sb_tag.push_back(tag);
    @(negedge clk);
    i_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // Record which cycles carried a request, so the ack can be predicted.
  always @(posedge clk) req_seen <= i_rst_n && (i_wr_en || i_rd_en);

  // Monitor: every cycle the ack must match the request history; reads are scored.
  always @(negedge clk) begin
    check_val("ack", 64'(o_ack), 64'(req_seen));
    if (req_seen) begin
      check_val("sb_depth", 64'(sb_rd.size() > 0), 64'd1);
      if (sb_rd.size() > 0) begin
        mon_rd  = sb_rd.pop_front();
        mon_exp = sb_exp.pop_front();
        mon_tag = sb_tag.pop_front();
        if (mon_rd) check_val(mon_tag, 64'(o_rdata), 64'(mon_exp));
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_addr = '0;
    i_wdata = '0; i_wr_mask = '0; i_ext_irq = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_timer_irq", 64'(o_timer_irq), 64'd0);
    check_val("rst_sw_irq", 64'(o_software_irq), 64'd0);
    check_val("rst_ext_irq", 64'(o_external_irq), 64'd0);
    check_val("rst_rdata", 64'(o_rdata), 64'd0);
    i_rst_n = 1'b1;

    // Prescaler: mtime advances on every 4th clock, 10 after 40 clocks
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) bus_rd(8'h00, 32'((40 + i) / 4), "mtime_count");
    bus_rd(8'h04, 32'd0, "mtime_hi_count");
    bus_rd(8'h08, 32'd1, "ctrl_reset");
    bus_rd(8'h14, 32'hFFFF_FFFF, "cmp0_hi_reset");

    // Compare: mtimecmp[0]=5, irq one cycle after mtime reaches 5, drop two cycles after hi write
    do_reset();
    bus_wr(8'h10, 32'd5);
    bus_wr(8'h14, 32'd0);
    repeat (18) @(negedge clk);
    check_val("tirq_before", 64'(o_timer_irq), 64'd0);
    @(negedge clk);
    check_val("tirq_rise", 64'(o_timer_irq), 64'd1);
    bus_wr(8'h14, 32'd1);
    check_val("tirq_hold", 64'(o_timer_irq), 64'd1);
    @(negedge clk);
    check_val("tirq_drop", 64'(o_timer_irq), 64'd0);

    // Coherent read across a low-word carry
    do_reset();
    bus_wr(8'h00, 32'hFFFF_FFFF);
    bus_rd(8'h00, 32'hFFFF_FFFF, "carry_lo_a");
    bus_rd(8'h04, 32'd0,         "carry_hi_a");
    bus_rd(8'h00, 32'hFFFF_FFFF, "carry_lo_b");
    bus_rd(8'h04, 32'd0,         "carry_hi_b");
    bus_rd(8'h00, 32'd0,         "carry_lo_c");
    bus_rd(8'h04, 32'd1,         "carry_hi_c");

    // 64-bit wrap to zero
    do_reset();
    bus_wr(8'h00, 32'hFFFF_FFFF);
    bus_wr(8'h04, 32'hFFFF_FFFF);
    bus_rd(8'h00, 32'hFFFF_FFFF, "wrap_lo_pre");
    bus_rd(8'h04, 32'hFFFF_FFFF, "wrap_hi_pre");
    bus_rd(8'h00, 32'd0,         "wrap_lo_post");
    bus_rd(8'h04, 32'd0,         "wrap_hi_post");

    // msip, unpopulated channels, unmapped offsets, byte masks
    bus_wr(8'h50, 32'hA);
    check_val("msip_out", 64'(o_software_irq), 64'hA);
    bus_wr(8'h50, 32'h5, 4'b0000);
    check_val("msip_mask0", 64'(o_software_irq), 64'hA);
    bus_rd(8'h50, 32'hA, "msip_rd");
    bus_wr(8'h48, 32'h1234);
    bus_wr(8'h30, 32'h55);
    bus_rd(8'h48, 32'd0, "ch_oob_48");
    bus_rd(8'h4C, 32'd0, "ch_oob_4c");
    bus_rd(8'h30, 32'd0, "ch_oob_30");
    bus_rd(8'h0C, 32'd0, "unmapped_0c");
    bus_rd(8'h2C, 32'hFFFF_FFFF, "cmp3_hi");
    bus_wr(8'h18, 32'h1122_3344, 4'b0101);
    bus_rd(8'h18, 32'hFF22_FF44, "byte_mask");

    // Edge-mode external interrupt
    i_ext_irq = 4'b0100;
    @(negedge clk);
    i_ext_irq = 4'b0000;
    @(negedge clk);
    check_val("ext_edge2", 64'(o_external_irq), 64'd0);
    @(negedge clk);
    check_val("ext_edge3", 64'(o_external_irq), 64'h4);
    repeat (5) @(negedge clk);
    check_val("ext_sticky", 64'(o_external_irq), 64'h4);
    bus_rd(8'h54, 32'h4, "ext_pend_rd");
    bus_wr(8'h54, 32'h4);
    check_val("ext_w1c", 64'(o_external_irq), 64'd0);
    i_ext_irq = 4'b0100;
    @(negedge clk);
    i_ext_irq = 4'b0000;
    @(negedge clk);
    bus_wr(8'h54, 32'h4);
    check_val("ext_set_wins", 64'(o_external_irq), 64'h4);
    bus_wr(8'h54, 32'h4);
    check_val("ext_clr2", 64'(o_external_irq), 64'd0);

    // Timer disable freezes mtime and prescaler phase
    do_reset();
    repeat (8) @(negedge clk);
    bus_wr(8'h08, 32'd0);
    repeat (100) @(negedge clk);
    bus_rd(8'h00, 32'd2, "frozen_mtime");
    bus_rd(8'h08, 32'd0, "ctrl_off");
    bus_wr(8'h08, 32'd1);
    bus_rd(8'h00, 32'd2, "resume_a");
    bus_rd(8'h00, 32'd2, "resume_b");
    bus_rd(8'h00, 32'd2, "resume_c");
    bus_rd(8'h00, 32'd3, "resume_d");

    // Write coincident with a tick keeps the written value
    do_reset();
    repeat (3) @(negedge clk);
    bus_wr(8'h00, 32'h100);
    bus_rd(8'h00, 32'h100, "wr_vs_tick");
    repeat (3) @(negedge clk);
    bus_rd(8'h00, 32'h101, "after_wr_tick");

    // Asynchronous reset mid-operation
    bus_wr(8'h50, 32'hF);
    bus_wr(8'h14, 32'd0);
    bus_wr(8'h10, 32'd0);
    i_ext_irq = 4'b0001;
    @(negedge clk);
    i_ext_irq = 4'b0000;
    repeat (4) @(negedge clk);
    check_val("pre_rst_timer", 64'(o_timer_irq), 64'd1);
    check_val("pre_rst_sw", 64'(o_software_irq), 64'hF);
    check_val("pre_rst_ext", 64'(o_external_irq), 64'd1);
    @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val("arst_timer", 64'(o_timer_irq), 64'd0);
    check_val("arst_sw", 64'(o_software_irq), 64'd0);
    check_val("arst_ext", 64'(o_external_irq), 64'd0);
    check_val("arst_rdata", 64'(o_rdata), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    bus_rd(8'h00, 32'd0,         "arst_mtime");
    bus_rd(8'h04, 32'd0,         "arst_shadow");
    bus_rd(8'h08, 32'd1,         "arst_ctrl");
    bus_rd(8'h10, 32'hFFFF_FFFF, "arst_cmp_lo");
    bus_rd(8'h14, 32'hFFFF_FFFF, "arst_cmp_hi");
    bus_rd(8'h50, 32'd0,         "arst_msip");
    bus_rd(8'h54, 32'd0,         "arst_pend");
    check_val("arst_timer_after", 64'(o_timer_irq), 64'd0);

    repeat (2) @(negedge clk);
    check_val("sb_empty", 64'(sb_rd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
